// File: rtl/ssr_pkg.sv
// rtl/ssr_pkg.sv - shared types and sizes for the speech-recognition datapath
package ssr_pkg;
    localparam int N_COEF = 26;
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] coef_t;

    typedef enum logic {
        HUNT = 1'b0,
        FILL = 1'b1
    } fa_state_e;
endpackage

// File: rtl/feature_assembler.sv
// rtl/feature_assembler.sv - assembles serial cepstral coefficients into an atomically published frame
module feature_assembler
    import ssr_pkg::*;
#(
    parameter int N_COEF = ssr_pkg::N_COEF,
    parameter int DATA_W = ssr_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_valid,
    input  logic                     coef_sof,
    input  logic signed [DATA_W-1:0] coef_data,
    output logic signed [DATA_W-1:0] input_vector [N_COEF-1:0],
    output logic                     vector_valid,
    output logic                     frame_err,
    output logic [7:0]               frame_count
);
    localparam int IDX_W = $clog2(N_COEF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    fa_state_e                state, state_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic                     wr_en;
    logic [IDX_W-1:0]         wr_idx;
    logic                     publish;
    logic                     err;
    logic signed [DATA_W-1:0] back [N_COEF-1:0];

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_en     = 1'b0;
        wr_idx    = idx;
        publish   = 1'b0;
        err       = 1'b0;
        if (coef_valid) begin
            case (state)
                HUNT: begin
                    if (coef_sof) begin
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        idx_nxt   = ONE_IDX;
                        state_nxt = FILL;
                    end else begin
                        err = 1'b1;
                    end
                end
                FILL: begin
                    // A new sof restarts the frame in place; the published vector is untouched.
                    if (coef_sof) begin
                        err     = 1'b1;
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        idx_nxt = ONE_IDX;
                    end else if (idx == LAST_IDX) begin
                        publish   = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        idx_nxt = idx + 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            idx          <= '0;
            vector_valid <= 1'b0;
            frame_err    <= 1'b0;
            frame_count  <= 8'd0;
            for (int i = 0; i < N_COEF; i++) begin
                back[i]         <= '0;
                input_vector[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            vector_valid <= publish;
            frame_err    <= err;
            if (wr_en) begin
                back[wr_idx] <= coef_data;
            end
            // The final coefficient bypasses the back buffer straight into the output register.
            if (publish) begin
                for (int i = 0; i < N_COEF - 1; i++) begin
                    input_vector[i] <= back[i];
                end
                input_vector[N_COEF-1] <= coef_data;
                frame_count            <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_feature_assembler.sv
// tb/tb_feature_assembler.sv - randomized scoreboard bench for feature_assembler
module tb_feature_assembler;
    localparam int N  = 26;
    localparam int W  = 16;
    localparam int VW = N * W;

    typedef struct packed {
        int            stamp;
        logic [7:0]    cnt;
        logic [VW-1:0] vec;
    } frame_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                coef_valid;
    logic                coef_sof;
    logic signed [W-1:0] coef_data;
    logic signed [W-1:0] input_vector [N-1:0];
    logic                vector_valid;
    logic                frame_err;
    logic [7:0]          frame_count;

    feature_assembler #(.N_COEF(N), .DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .coef_valid   (coef_valid),
        .coef_sof     (coef_sof),
        .coef_data    (coef_data),
        .input_vector (input_vector),
        .vector_valid (vector_valid),
        .frame_err    (frame_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    logic [VW-1:0] dut_flat;
    always_comb begin
        dut_flat = '0;
        for (int i = 0; i < N; i++) dut_flat[i*W +: W] = input_vector[i];
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input bit ok, input logic [VW-1:0] act, input logic [VW-1:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Reference model: a frame is simply the list of coefficients since the last sof.
    frame_t              exp_f [$];
    int                  exp_e [$];
    logic signed [W-1:0] part [$];
    bit                  in_frame    = 1'b0;
    int                  model_count = 0;

    task automatic model_step(input bit v, input bit s, input logic signed [W-1:0] d);
        frame_t f;
        if (!v) return;
        if (s) begin
            if (in_frame) exp_e.push_back(cyc + 1);
            part.delete();
            part.push_back(d);
            in_frame = 1'b1;
        end else if (!in_frame) begin
            exp_e.push_back(cyc + 1);
        end else begin
            part.push_back(d);
            if (part.size() == N) begin
                model_count = (model_count + 1) % 256;
                f.stamp = cyc + 1;
                f.cnt   = 8'(model_count);
                f.vec   = '0;
                for (int i = 0; i < N; i++) f.vec[i*W +: W] = part[i];
                exp_f.push_back(f);
                part.delete();
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic signed [W-1:0] d);
        coef_valid = v;
        coef_sof   = s;
        coef_data  = d;
        model_step(v, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, W'($urandom));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        coef_valid = 1'b0;
        coef_sof   = 1'b0;
        part.delete();
        in_frame    = 1'b0;
        model_count = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input bit ramp, input logic signed [W-1:0] first);
        for (int k = 0; k < N; k++) begin
            if (k > 0 && gap_max > 0) idle($urandom_range(gap_max, 0));
            if (ramp) drive(1'b1, k == 0, (k == 0) ? first : W'(k));
            else      drive(1'b1, k == 0, W'($urandom));
        end
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, k == 0, W'($urandom));
    endtask

    logic [VW-1:0] mon_last  = '0;
    logic [7:0]    mon_count = 8'd0;

    always @(negedge clk) begin
        frame_t f;
        int     s;
        if (rst_q) begin
            chk("reset_values", !vector_valid && !frame_err && frame_count == 8'd0 && dut_flat == '0,
                {vector_valid, frame_err, frame_count, dut_flat == '0}, {1'b0, 1'b0, 8'd0, 1'b1});
            mon_last  = '0;
            mon_count = 8'd0;
        end else begin
            if (vector_valid) begin
                if (exp_f.size() == 0) begin
                    chk("unexpected_vector_valid", 1'b0, VW'(cyc), '0);
                end else begin
                    f = exp_f.pop_front();
                    chk("frame_timing", f.stamp == cyc, VW'(cyc), VW'(f.stamp));
                    chk("frame_contents", dut_flat == f.vec, dut_flat, f.vec);
                    chk("frame_count", frame_count == f.cnt, VW'(frame_count), VW'(f.cnt));
                    mon_last  = f.vec;
                    mon_count = f.cnt;
                end
            end else if (exp_f.size() != 0 && exp_f[0].stamp < cyc) begin
                f = exp_f.pop_front();
                chk("missed_vector_valid", 1'b0, VW'(cyc), VW'(f.stamp));
                mon_last  = f.vec;
                mon_count = f.cnt;
            end
            chk("vector_hold", dut_flat == mon_last && frame_count == mon_count,
                {dut_flat, frame_count}, {mon_last, mon_count});
            if (frame_err) begin
                if (exp_e.size() == 0) begin
                    chk("unexpected_frame_err", 1'b0, VW'(cyc), '0);
                end else begin
                    s = exp_e.pop_front();
                    chk("frame_err_timing", s == cyc, VW'(cyc), VW'(s));
                end
            end else if (exp_e.size() != 0 && exp_e[0] < cyc) begin
                s = exp_e.pop_front();
                chk("missed_frame_err", 1'b0, VW'(cyc), VW'(s));
            end
        end
    end

    initial begin
        rst        = 1'b1;
        coef_valid = 1'b0;
        coef_sof   = 1'b0;
        coef_data  = '0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // nominal frame: -5 then 1..25
        send_frame(0, 1'b1, -16'sd5);
        idle(2);
        chk("nominal_idx0", input_vector[0] == -16'sd5, VW'(input_vector[0]), VW'(16'hfffb));
        chk("nominal_idx25", input_vector[N-1] == 16'sd25, VW'(input_vector[N-1]), VW'(25));
        chk("nominal_count", frame_count == 8'd1, VW'(frame_count), VW'(1));

        // gapped frames, second starting right after the first
        send_frame(3, 1'b0, '0);
        send_frame(3, 1'b0, '0);
        idle(2);
        chk("gapped_count", frame_count == 8'd3, VW'(frame_count), VW'(3));

        // premature sof
        send_partial(11);
        send_frame(0, 1'b0, '0);
        idle(2);

        // stray data in HUNT
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, W'($urandom));
        idle(2);
        chk("stray_vector_zero", dut_flat == '0, dut_flat, '0);

        // reset mid-frame
        send_frame(0, 1'b0, '0);
        send_partial(12);
        do_reset();
        send_frame(1, 1'b0, '0);
        idle(2);
        chk("post_reset_count", frame_count == 8'd1, VW'(frame_count), VW'(1));

        // counter wrap: 257 back-to-back frames
        do_reset();
        for (int f = 0; f < 257; f++) send_frame(0, 1'b0, '0);
        idle(2);
        chk("wrap_count", frame_count == 8'd1, VW'(frame_count), VW'(1));

        // random traffic
        for (int i = 0; i < 600; i++)
            drive($urandom_range(1, 0) == 1, $urandom_range(39, 0) == 0, W'($urandom));
        idle(3);

        chk("frames_drained", exp_f.size() == 0, VW'(exp_f.size()), '0);
        chk("errs_drained", exp_e.size() == 0, VW'(exp_e.size()), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
